channel_4_noise_voice: RTL and testbench

Downstream consumer of the channel 4 note sequencer. Takes its per-note phase delta and 9-bit envelope and produces the channel 4 audio sample. A 32-bit phase accumulator clocks a 15-bit NES-style noise LFSR; LFSR bit 0 sets the sign of the envelope-scaled output. Output is a signed sample for the mixer, produced once per audio sample strobe.

---
 rtl/channel_4_noise_voice_pkg.sv | 23 ++
 rtl/channel_4_noise_voice_if.sv | 23 ++
 rtl/channel_4_noise_voice_lfsr.sv | 29 ++
 rtl/channel_4_noise_voice.sv | 79 +++++++
 tb/tb_channel_4_noise_voice.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/channel_4_noise_voice_pkg.sv
// Channel 4 noise voice: shared widths, LFSR seed/taps and the sign helper.
package channel_4_noise_voice_pkg;

  localparam int ACC_WIDTH    = 32;
  localparam int ENV_WIDTH    = 9;
  localparam int SAMPLE_WIDTH = ENV_WIDTH + 1;
  localparam int LFSR_WIDTH   = 15;

  // Must be nonzero: the feedback rule has no way out of the all-zero state.
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 15'h0001;

  localparam int LONG_TAP  = 1;
  localparam int SHORT_TAP = 6;

  // Zero-extend the envelope first so that negating the full 0x1FF still fits.
  function automatic logic [SAMPLE_WIDTH-1:0] apply_sign(input logic [ENV_WIDTH-1:0] env,
                                                         input logic negate);
    logic [SAMPLE_WIDTH-1:0] mag;
    mag = {1'b0, env};
    return negate ? -mag : mag;
  endfunction

endpackage

// File: rtl/channel_4_noise_voice_if.sv
// Sequencer-to-voice bus: strobe, note parameters in, mixer sample out.
interface channel_4_noise_voice_if;
  import channel_4_noise_voice_pkg::*;

  logic                    i_sample_stb;
  logic [ACC_WIDTH-1:0]    i_phase_delta;
  logic [ENV_WIDTH-1:0]    i_envelope;
  logic                    i_short_mode;
  logic [SAMPLE_WIDTH-1:0] o_sample;
  logic                    o_sample_valid;
  logic                    o_lfsr_stb;

  modport master (
    output i_sample_stb, i_phase_delta, i_envelope, i_short_mode,
    input  o_sample, o_sample_valid, o_lfsr_stb
  );

  modport slave (
    input  i_sample_stb, i_phase_delta, i_envelope, i_short_mode,
    output o_sample, o_sample_valid, o_lfsr_stb
  );

endinterface

// File: rtl/channel_4_noise_voice_lfsr.sv
// 15-bit NES-style noise LFSR; shifts right, feedback enters at bit 14.
module noise_lfsr15
  import channel_4_noise_voice_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  shift_en_i,
  input  logic                  short_mode_i,
  output logic [LFSR_WIDTH-1:0] state_o
);

  logic [LFSR_WIDTH-1:0] state_q, state_d;
  logic                  fb;

  // Feedback and next state; mode is read at shift time so a change never reseeds.
  always_comb begin
    fb      = state_q[0] ^ (short_mode_i ? state_q[SHORT_TAP] : state_q[LONG_TAP]);
    state_d = shift_en_i ? {fb, state_q[LFSR_WIDTH-1:1]} : state_q;
  end

  // State register; reset wins over a coincident shift request.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= LFSR_SEED;
    else          state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/channel_4_noise_voice.sv
// Channel 4 noise voice: phase accumulator carry clocks the LFSR, LFSR bit 0
// signs the envelope. Two-stage pipeline: capture on strobe, sample one cycle later.
module channel_4_noise_voice
  import channel_4_noise_voice_pkg::*;
(
  input logic                    i_clk,
  input logic                    i_rst_n,
  channel_4_noise_voice_if.slave bus
);

  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    carry;
  logic                    shift_en;
  logic [LFSR_WIDTH-1:0]   lfsr_q;

  logic                    s1_valid_q;
  logic [ENV_WIDTH-1:0]    s1_env_q;
  logic                    s1_mute_q;

  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    sample_valid_q;
  logic                    lfsr_stb_q;

  // Modulo accumulator sum; the carry out is the LFSR clock.
  always_comb begin
    {carry, acc_d} = {1'b0, acc_q} + {1'b0, bus.i_phase_delta};
  end

  // A zero delta never carries, so mute freezes the LFSR without extra gating.
  assign shift_en = bus.i_sample_stb & carry;

  noise_lfsr15 u_lfsr (
    .clk_i        (i_clk),
    .rst_n_i      (i_rst_n),
    .shift_en_i   (shift_en),
    .short_mode_i (bus.i_short_mode),
    .state_o      (lfsr_q)
  );

  // Stage 1: advance accumulator and capture note parameters on the strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_env_q   <= '0;
      s1_mute_q  <= 1'b0;
      lfsr_stb_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.i_sample_stb;
      lfsr_stb_q <= shift_en;
      if (bus.i_sample_stb) begin
        acc_q     <= acc_d;
        s1_env_q  <= bus.i_envelope;
        s1_mute_q <= (bus.i_phase_delta == '0);
      end
    end
  end

  // Stage-2 value; lfsr_q here already reflects any shift from the captured strobe.
  always_comb begin
    sample_d = s1_mute_q ? '0 : apply_sign(s1_env_q, lfsr_q[0]);
  end

  // Stage 2: publish the sample and its one-cycle valid; hold between valids.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= s1_valid_q;
      if (s1_valid_q) sample_q <= sample_d;
    end
  end

  assign bus.o_sample       = sample_q;
  assign bus.o_sample_valid = sample_valid_q;
  assign bus.o_lfsr_stb     = lfsr_stb_q;

endmodule

// File: tb/tb_channel_4_noise_voice.sv
// Bench for channel_4_noise_voice: per-cycle comparison against a queue-based model.
module tb_channel_4_noise_voice;
  import channel_4_noise_voice_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  channel_4_noise_voice_if bus ();

  channel_4_noise_voice dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [9:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] m_acc    = '0;
  logic [14:0] m_lfsr   = 15'h0001;
  logic        m_stb    = 1'b0;
  logic [9:0]  m_sample = '0;

  function automatic logic [14:0] ref_shift(input logic [14:0] l, input logic short_m);
    int x, tap, fb;
    x   = int'(l);
    tap = short_m ? 6 : 1;
    fb  = (x ^ (x >> tap)) & 1;
    return 15'((x >> 1) | (fb << 14));
  endfunction

  function automatic logic [9:0] ref_sample(input logic [31:0] delta, input logic [8:0] env,
                                            input logic [14:0] l);
    int e;
    e = int'(env);
    if (delta == 0) return 10'd0;
    return (l[0] == 1'b1) ? 10'((1024 - e) % 1024) : 10'(e);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Advance model with the inputs present at the coming edge, then compare.
  task automatic tick();
    logic [32:0] sum;
    logic        v_exp;
    if (!rst_n) begin
      m_acc    = '0;
      m_lfsr   = 15'h0001;
      m_stb    = 1'b0;
      m_sample = '0;
      exp_q.delete();
    end else begin
      m_stb = 1'b0;
      if (bus.i_sample_stb) begin
        sum   = {1'b0, m_acc} + {1'b0, bus.i_phase_delta};
        m_acc = sum[31:0];
        if (sum[32]) begin
          m_lfsr = ref_shift(m_lfsr, bus.i_short_mode);
          m_stb  = 1'b1;
        end
        exp_q.push_back('{due: cyc + 2,
                          val: ref_sample(bus.i_phase_delta, bus.i_envelope, m_lfsr)});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    v_exp = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      v_exp    = 1'b1;
      m_sample = exp_q[0].val;
      void'(exp_q.pop_front());
    end
    chk("valid", 32'(bus.o_sample_valid), 32'(v_exp));
    chk("lfsr_stb", 32'(bus.o_lfsr_stb), 32'(m_stb));
    chk("sample", 32'(bus.o_sample), 32'(m_sample));
    chk("lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
    chk("acc", dut.acc_q, m_acc);
  endtask

  task automatic reset_dut();
    rst_n            = 1'b0;
    bus.i_sample_stb = 1'b1;
    repeat (3) tick();
    rst_n            = 1'b1;
    bus.i_sample_stb = 1'b0;
  endtask

  initial begin
    int          cnt;
    logic [14:0] sv_lfsr;
    logic [31:0] sv_acc;

    bus.i_sample_stb  = 1'b1;
    bus.i_phase_delta = 32'h1234_5678;
    bus.i_envelope    = 9'd77;
    bus.i_short_mode  = 1'b0;

    // Reset with strobe held high.
    reset_dut();
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0001);
    chk("rst_sample", 32'(bus.o_sample), 32'h0);
    chk("rst_valid", 32'(bus.o_sample_valid), 32'h0);

    // Half-rate strobes, delta = 2^31, env = 20.
    bus.i_phase_delta = 32'h8000_0000;
    bus.i_envelope    = 9'd20;
    bus.i_sample_stb  = 1'b1; tick();
    bus.i_sample_stb  = 1'b0; tick();
    chk("half_v1", 32'(bus.o_sample_valid), 32'h1);
    chk("half_s1", 32'(bus.o_sample), 32'h3EC);
    chk("half_l1", 32'(dut.lfsr_q), 32'h0001);
    bus.i_sample_stb  = 1'b1; tick();
    chk("half_stb", 32'(bus.o_lfsr_stb), 32'h1);
    chk("half_l2", 32'(dut.lfsr_q), 32'h4000);
    bus.i_sample_stb  = 1'b0; tick();
    chk("half_v2", 32'(bus.o_sample_valid), 32'h1);
    chk("half_s2", 32'(bus.o_sample), 32'h014);
    tick();
    chk("half_hold", 32'(bus.o_sample), 32'h014);

    // Long-mode period.
    reset_dut();
    bus.i_phase_delta = 32'hFFFF_FFFF;
    bus.i_short_mode  = 1'b0;
    bus.i_sample_stb  = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40000; k++) begin
      tick();
      if (bus.o_lfsr_stb) cnt++;
      if (cnt > 0 && dut.lfsr_q == 15'h0001) break;
    end
    chk("long_period", 32'(cnt), 32'd32767);

    // Short-mode period from reset.
    reset_dut();
    bus.i_short_mode = 1'b1;
    bus.i_sample_stb = 1'b1;
    cnt = 0;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (bus.o_lfsr_stb) cnt++;
      if (cnt > 0 && dut.lfsr_q == 15'h0001) break;
    end
    chk("short_period", 32'(cnt), 32'd93);

    // Mute after 5 shifts, then resume.
    reset_dut();
    bus.i_short_mode  = 1'b0;
    bus.i_phase_delta = 32'hFFFF_FFFF;
    bus.i_envelope    = 9'd100;
    bus.i_sample_stb  = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 5; k++) begin
      tick();
      if (bus.o_lfsr_stb) cnt++;
    end
    chk("pre_mute_shifts", 32'(cnt), 32'd5);
    sv_lfsr = m_lfsr;
    sv_acc  = m_acc;
    bus.i_phase_delta = 32'h0;
    cnt = 0;
    repeat (10) begin
      tick();
      if (bus.o_lfsr_stb) cnt++;
    end
    chk("mute_no_stb", 32'(cnt), 32'd0);
    chk("mute_lfsr", 32'(dut.lfsr_q), 32'(sv_lfsr));
    chk("mute_acc", dut.acc_q, sv_acc);
    chk("mute_sample", 32'(bus.o_sample), 32'h0);
    bus.i_phase_delta = 32'hFFFF_FFFF;
    repeat (6) tick();
    chk("unmute_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));

    // Envelope captured at the strobe, not afterwards.
    bus.i_phase_delta = 32'h0000_0001;
    bus.i_envelope    = 9'h1FF;
    bus.i_sample_stb  = 1'b1; tick();
    bus.i_envelope    = 9'h000;
    bus.i_sample_stb  = 1'b0; tick();
    chk("cap_valid", 32'(bus.o_sample_valid), 32'h1);
    chk("cap_nonzero", 32'(bus.o_sample == 10'h1FF || bus.o_sample == 10'h201), 32'h1);

    // Reset in the cycle after a strobe drops the pending valid.
    bus.i_envelope   = 9'd55;
    bus.i_sample_stb = 1'b1; tick();
    rst_n            = 1'b0;
    bus.i_sample_stb = 1'b0; tick();
    rst_n            = 1'b1; tick();
    chk("midrst_valid", 32'(bus.o_sample_valid), 32'h0);
    chk("midrst_lfsr", 32'(dut.lfsr_q), 32'h0001);
    chk("midrst_acc", dut.acc_q, 32'h0);
    chk("midrst_sample", 32'(bus.o_sample), 32'h0);

    // Randomized traffic including mute, mode flips and occasional resets.
    for (int k = 0; k < 600; k++) begin
      bus.i_sample_stb = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       bus.i_phase_delta = 32'h0;
        1:       bus.i_phase_delta = 32'hF000_0000 | $urandom();
        default: bus.i_phase_delta = $urandom();
      endcase
      bus.i_envelope = 9'($urandom());
      if ($urandom_range(0, 15) == 0) bus.i_short_mode = ~bus.i_short_mode;
      rst_n = ($urandom_range(0, 63) != 0);
      tick();
    end
    rst_n = 1'b1;
    bus.i_sample_stb = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
